// File: rtl/sram_pkg.sv
// Shared types and parameter bounds for the
// 16-bit SRAM word controller.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } sram_state_t;

  localparam int unsigned WORD_W_MIN = 16;
  localparam int unsigned WORD_W_MAX = 64;
  localparam int unsigned WAIT_MAX   = 7;
  localparam int unsigned WAIT_CNT_W = 3;

  // Power of two keeps the byte-to-word shift exact.
  function automatic bit word_w_legal(
    input int unsigned w
  );
    return (w >= WORD_W_MIN)
        && (w <= WORD_W_MAX)
        && ((w & (w - 1)) == 0);
  endfunction

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_beat_counter.sv
// Beat and wait-state sequencing for one
// word access split into 16-bit beats.
module sram_beat_counter
  import sram_pkg::*;
#(
  parameter int unsigned BEATS       = 2,
  parameter int unsigned WAIT_STATES = 1,
  localparam int unsigned BEAT_W     = cnt_w(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [BEAT_W-1:0] beat,
  output logic              beat_last,
  output logic              op_last
);

  logic [WAIT_CNT_W-1:0] wait_q;
  logic [BEAT_W-1:0]     beat_q;

  assign beat      = beat_q;
  assign beat_last = (wait_q == WAIT_CNT_W'(WAIT_STATES));
  assign op_last   = beat_last
                  && (beat_q == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      beat_q <= '0;
    end else if (!en || op_last) begin
      wait_q <= '0;
      beat_q <= '0;
    end else if (beat_last) begin
      wait_q <= '0;
      beat_q <= beat_q + 1'b1;
    end else begin
      wait_q <= wait_q + 1'b1;
    end
  end

endmodule

// File: rtl/sram_word_ctrl.sv
// Word-wide read/write front end for an
// asynchronous 16-bit SRAM.
module sram_word_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [WORD_W-1:0]      wdata,
  output logic [WORD_W-1:0]      rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]            SRAM_DQ,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int unsigned BEATS  = WORD_W / 16;
  localparam int unsigned BEAT_W = cnt_w(BEATS);
  localparam int unsigned SHIFT  = $clog2(WORD_W / 8);

  if (!word_w_legal(WORD_W)
      || (WAIT_STATES > WAIT_MAX)) begin : g_bad_param
    $error("sram_word_ctrl: illegal WORD_W/WAIT_STATES");
  end

  sram_state_t       state_q;
  sram_state_t       state_d;
  logic              req;
  logic              accept;
  logic              in_access;
  logic              drive_dq;
  logic              is_wr_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic [31:0]       word_idx;
  logic [15:0]       wr_beat;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W+3:0] beat_lsb;
  logic              beat_last;
  logic              op_last;

  assign req = wr_en | rd_en;

  sram_beat_counter #(
    .BEATS       (BEATS),
    .WAIT_STATES (WAIT_STATES)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst),
    .en        (in_access),
    .beat      (beat),
    .beat_last (beat_last),
    .op_last   (op_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req) state_d = ST_ACCESS;
      ST_ACCESS: if (op_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    accept    = 1'b0;
    in_access = 1'b0;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        ready  = !req;
        accept = req;
      end
      state_q == ST_ACCESS: in_access = 1'b1;
      state_q == ST_DONE:   ready     = 1'b1;
      default: ;
    endcase
    // Reset must show ready even with a request held.
    if (!rst) begin
      ready  = 1'b1;
      accept = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      is_wr_q <= wr_en;
      addr_q  <= address;
      wdata_q <= wdata;
    end
  end

  assign beat_lsb = {beat, 4'b0000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (in_access && !is_wr_q
                 && beat_last) begin
      rdata_q[beat_lsb +: 16] <= SRAM_DQ;
    end
  end

  assign word_idx = (addr_q - BASE_ADDR) >> SHIFT;
  assign wr_beat  = wdata_q[beat_lsb +: 16];
  assign drive_dq = in_access && is_wr_q;

  assign SRAM_ADDR = in_access
    ? SRAM_ADDR_W'(word_idx * 32'(BEATS)
                   + 32'(beat))
    : '0;

  assign SRAM_DQ   = drive_dq ? wr_beat : 16'hzzzz;
  assign SRAM_WE_N = !drive_dq;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Scoreboard bench: 32-bit/1-wait and 64-bit/0-wait
// controllers, each on its own behavioural SRAM.
module tb_sram_word_ctrl;

  localparam int AW   = 10;
  localparam int MEMN = 1 << AW;

  typedef struct packed {
    bit              is_rd;
    logic [63:0]     data;
    int              lat;
    int              n;
    logic [3:0][9:0] a;
    logic [3:0][15:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic mem_clr;

  logic          a_wr, a_rd, a_ready;
  logic [31:0]   a_addr, a_wdata, a_rdata;
  logic [AW-1:0] a_sa;
  wire  [15:0]   a_dq;
  logic          a_we, a_ub, a_lb, a_ce, a_oe;

  logic          b_wr, b_rd, b_ready;
  logic [31:0]   b_addr;
  logic [63:0]   b_wdata, b_rdata;
  logic [AW-1:0] b_sa;
  wire  [15:0]   b_dq;
  logic          b_we, b_ub, b_lb, b_ce, b_oe;

  sram_word_ctrl #(
    .WORD_W(32), .SRAM_ADDR_W(AW),
    .WAIT_STATES(1), .BASE_ADDR(32'd1024)
  ) u_a (
    .clk(clk), .rst(rst),
    .wr_en(a_wr), .rd_en(a_rd),
    .address(a_addr), .wdata(a_wdata),
    .rdata(a_rdata), .ready(a_ready),
    .SRAM_ADDR(a_sa), .SRAM_DQ(a_dq),
    .SRAM_WE_N(a_we), .SRAM_UB_N(a_ub),
    .SRAM_LB_N(a_lb), .SRAM_CE_N(a_ce),
    .SRAM_OE_N(a_oe)
  );

  sram_word_ctrl #(
    .WORD_W(64), .SRAM_ADDR_W(AW),
    .WAIT_STATES(0), .BASE_ADDR(32'd1024)
  ) u_b (
    .clk(clk), .rst(rst),
    .wr_en(b_wr), .rd_en(b_rd),
    .address(b_addr), .wdata(b_wdata),
    .rdata(b_rdata), .ready(b_ready),
    .SRAM_ADDR(b_sa), .SRAM_DQ(b_dq),
    .SRAM_WE_N(b_we), .SRAM_UB_N(b_ub),
    .SRAM_LB_N(b_lb), .SRAM_CE_N(b_ce),
    .SRAM_OE_N(b_oe)
  );

  // Asynchronous SRAM models.
  logic [15:0] mem_a [MEMN];
  logic [15:0] mem_b [MEMN];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEMN; i++) mem_a[i] <= '0;
    end else if (!a_we && !a_ce) begin
      mem_a[a_sa] <= a_dq;
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEMN; i++) mem_b[i] <= '0;
    end else if (!b_we && !b_ce) begin
      mem_b[b_sa] <= b_dq;
    end
  end

  assign a_dq = (a_we && !a_oe && !a_ce)
              ? mem_a[a_sa] : 16'hzzzz;
  assign b_dq = (b_we && !b_oe && !b_ce)
              ? mem_b[b_sa] : 16'hzzzz;

  // Reference contents, indexed by SRAM halfword.
  logic [15:0] ref_a [MEMN];
  logic [15:0] ref_b [MEMN];

  exp_t qa[$];
  exp_t qb[$];
  bit   done_a, done_b;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic exp_t build(
    input int          inst,
    input bit          wr,
    input bit          rd,
    input logic [31:0] addr,
    input logic [63:0] data
  );
    exp_t e;
    int beats, ws, base;
    longint unsigned off;
    beats   = inst ? 4 : 2;
    ws      = inst ? 0 : 1;
    e       = '0;
    e.n     = beats;
    e.lat   = beats * (ws + 1) + 1;
    e.is_rd = rd && !wr;
    off  = {32'd0, addr - 32'd1024};
    base = int'(((off / longint'(beats * 2))
                 * longint'(beats)) % MEMN);
    for (int k = 0; k < beats; k++) begin
      e.a[k] = 10'((base + k) % MEMN);
      if (wr) begin
        e.d[k] = data[16*k +: 16];
        if (inst != 0) ref_b[e.a[k]] = e.d[k];
        else           ref_a[e.a[k]] = e.d[k];
      end else begin
        e.data[16*k +: 16] = (inst != 0)
          ? ref_b[e.a[k]] : ref_a[e.a[k]];
      end
    end
    return e;
  endfunction

  task automatic op(input int          inst,
                    input bit          wr,
                    input bit          rd,
                    input logic [31:0] addr,
                    input logic [63:0] data);
    exp_t e;
    bit   ok;
    e = build(inst, wr, rd, addr, data);
    if (inst == 0) begin
      qa.push_back(e);
      done_a  = 1'b0;
      a_wr    = wr;
      a_rd    = rd;
      a_addr  = addr;
      a_wdata = data[31:0];
    end else begin
      qb.push_back(e);
      done_b  = 1'b0;
      b_wr    = wr;
      b_rd    = rd;
      b_addr  = addr;
      b_wdata = data;
    end
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      ok = (inst == 0) ? done_a : done_b;
      if (ok) break;
      // Inputs are scrambled while the op is in flight.
      if (inst == 0) begin
        a_wr    = 1'($urandom);
        a_rd    = 1'($urandom);
        a_addr  = $urandom;
        a_wdata = $urandom;
      end else begin
        b_wr    = 1'($urandom);
        b_rd    = 1'($urandom);
        b_addr  = $urandom;
        b_wdata = {$urandom, $urandom};
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL op_timeout: inst %0d got no ready",
               inst);
    end
    a_wr = 1'b0;
    a_rd = 1'b0;
    b_wr = 1'b0;
    b_rd = 1'b0;
  endtask

  task automatic mon(input int inst);
    int          cnt;
    bit          we_seen;
    bit          rdy;
    bit          we;
    logic [63:0] rd;
    logic [15:0] m;
    exp_t        e;
    cnt     = 0;
    we_seen = 1'b0;
    forever begin
      @(negedge clk);
      rdy = (inst == 0) ? a_ready : b_ready;
      we  = (inst == 0) ? a_we    : b_we;
      rd  = (inst == 0) ? {32'd0, a_rdata} : b_rdata;
      if (!rst) begin
        cnt     = 0;
        we_seen = 1'b0;
      end else if (!rdy) begin
        cnt++;
        if (!we) we_seen = 1'b1;
      end else if (cnt > 0) begin
        if ((inst == 0 ? qa.size() : qb.size()) == 0) begin
          chk("unexpected_done", 64'(cnt), 64'd0);
        end else begin
          e = (inst == 0) ? qa.pop_front()
                          : qb.pop_front();
          chk("latency", 64'(cnt), 64'(e.lat));
          if (e.is_rd) begin
            chk("rdata", rd, e.data);
            chk("read_we_low", 64'(we_seen), 64'd0);
          end else begin
            chk("write_we_low", 64'(we_seen), 64'd1);
            for (int k = 0; k < e.n; k++) begin
              m = (inst == 0) ? mem_a[e.a[k]]
                              : mem_b[e.a[k]];
              chk("sram_word", 64'(m), 64'(e.d[k]));
            end
          end
        end
        cnt     = 0;
        we_seen = 1'b0;
        if (inst == 0) done_a = 1'b1;
        else           done_b = 1'b1;
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          inst;
    int          kind;
    logic [31:0] addr;

    for (int i = 0; i < MEMN; i++) begin
      ref_a[i] = '0;
      ref_b[i] = '0;
    end
    rst     = 1'b0;
    mem_clr = 1'b1;
    a_wr = 1'b0; a_rd = 1'b0;
    a_addr = '0; a_wdata = '0;
    b_wr = 1'b0; b_rd = 1'b0;
    b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    chk("rst_ready_a", 64'(a_ready), 64'd1);
    chk("rst_ready_b", 64'(b_ready), 64'd1);
    chk("rst_we_a", 64'(a_we), 64'd1);
    chk("rst_addr_a", 64'(a_sa), 64'd0);
    chk("rst_rdata_a", 64'(a_rdata), 64'd0);
    chk("rst_rdata_b", b_rdata, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    op(0, 1'b1, 1'b0, 32'd1024, 64'hDEADBEEF);
    chk("w0_lo", 64'(mem_a[0]), 64'hBEEF);
    chk("w0_hi", 64'(mem_a[1]), 64'hDEAD);
    op(0, 1'b0, 1'b1, 32'd1024, 64'h5555AAAA);
    chk("r0_hold", 64'(a_rdata), 64'hDEADBEEF);
    op(0, 1'b1, 1'b1, 32'd1028, 64'h12345678);
    chk("wr_prio_lo", 64'(mem_a[2]), 64'h5678);
    chk("wr_prio_hi", 64'(mem_a[3]), 64'h1234);
    chk("wr_prio_rd", 64'(a_rdata), 64'hDEADBEEF);

    // Reset in beat 1 of a write to halfwords 6/7.
    a_wr    = 1'b1;
    a_addr  = 32'd1036;
    a_wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(a_ready), 64'd1);
    chk("mid_rst_we", 64'(a_we), 64'd1);
    chk("mid_rst_addr", 64'(a_sa), 64'd0);
    chk("mid_rst_rdata", 64'(a_rdata), 64'd0);
    @(negedge clk);
    chk("rst_edge_ready", 64'(a_ready), 64'd1);
    chk("rst_edge_we", 64'(a_we), 64'd1);
    @(posedge clk);
    #1;
    a_wr = 1'b0;
    rst  = 1'b1;
    ref_a[6] = 16'hF00D;
    chk("hi_abandoned", 64'(mem_a[7]), 64'h0);
    @(posedge clk);
    #1;
    op(0, 1'b0, 1'b1, 32'd1024, 64'd0);
    op(0, 1'b0, 1'b1, 32'd1036, 64'd0);

    op(1, 1'b1, 1'b0, 32'd1032,
       64'h0123456789ABCDEF);
    chk("b_w4", 64'(mem_b[4]), 64'hCDEF);
    chk("b_w5", 64'(mem_b[5]), 64'h89AB);
    chk("b_w6", 64'(mem_b[6]), 64'h4567);
    chk("b_w7", 64'(mem_b[7]), 64'h0123);
    op(1, 1'b0, 1'b1, 32'd1032, 64'd0);
    chk("b_rd_hold", b_rdata, 64'h0123456789ABCDEF);

    for (int i = 0; i < 180; i++) begin
      inst = (i % 3 == 2) ? 1 : 0;
      kind = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = $urandom;
      else addr = 32'd1024 + $urandom_range(0, 6000);
      op(inst, kind == 0 || kind == 2, kind >= 1,
         addr, {$urandom, $urandom});
    end

    repeat (4) @(posedge clk);
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
